// File: rtl/alu_share_arbiter.sv
// Shares one 8-bit ALU among NREQ requesters through a round-robin req/done handshake.
// Define ARB_FIXED_PRIO_EN to make the lowest-index requester always win instead.
module alu_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   Req,
  input  logic [8*NREQ-1:0] OpA,
  input  logic [8*NREQ-1:0] OpB,
  input  logic [4*NREQ-1:0] OpCode,
  output logic [NREQ-1:0]   Grant,
  output logic [NREQ-1:0]   Done,
  output logic [7:0]        Result,
  output logic              Zero,
  output logic              Carry_out,
  output logic              Overflow,
  output logic              Busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StExec = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpNot = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpInc = 4'h8;
  localparam logic [3:0] OpDec = 4'h9;

  state_e          state_q, state_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [7:0]      res_q, res_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;

  logic            arb_valid;
  logic [PW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_oh;

  logic            req_win;
  logic [7:0]      sel_a, sel_b;
  logic [3:0]      sel_op;

  logic [8:0]      alu_wide;
  logic [7:0]      alu_opb;
  logic [7:0]      alu_res;
  logic            alu_c, alu_v;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    arb_valid = |Req;
    arb_idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (Req[i]) arb_idx = PW'(i);
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  logic [31:0]   cand;

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!arb_valid && Req[i] && (cand == i)) begin
          arb_valid = 1'b1;
          arb_idx   = PW'(i);
        end
      end
    end
  end

  // Any exit from a busy state (release or abort) makes the winner lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q != StIdle) && !req_win) ptr_d = win_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PW'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    arb_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_oh[i] = (arb_idx == PW'(i));
    end
  end

  // Operand and request mux for the current winner.
  always_comb begin
    req_win = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_q == PW'(i)) begin
        req_win = Req[i];
        sel_a   = OpA[8*i +: 8];
        sel_b   = OpB[8*i +: 8];
        sel_op  = OpCode[4*i +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU8 on the latched operands
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_opb  = ((op_q == OpInc) || (op_q == OpDec)) ? 8'h01 : b_q;
    alu_wide = '0;
    alu_res  = a_q;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_q)
      OpAdd, OpInc: begin
        alu_wide = {1'b0, a_q} + {1'b0, alu_opb};
        alu_res  = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (a_q[7] == alu_opb[7]) && (alu_res[7] != a_q[7]);
      end
      OpSub, OpDec: begin
        // Carry_out is the borrow for subtraction.
        alu_wide = {1'b0, a_q} - {1'b0, alu_opb};
        alu_res  = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (a_q[7] != alu_opb[7]) && (alu_res[7] != a_q[7]);
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpShl: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      OpShr: begin
        alu_res = {1'b0, a_q[7:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = a_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    grant_d = grant_q;
    done_d  = done_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          grant_d = arb_oh;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!req_win) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!req_win) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          res_d   = alu_res;
          zero_d  = (alu_res == 8'h00);
          carry_d = alu_c;
          ovf_d   = alu_v;
          done_d  = grant_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!req_win) begin
          grant_d = '0;
          done_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        win_d   = '0;
        grant_d = '0;
        done_d  = '0;
        a_d     = '0;
        b_d     = '0;
        op_d    = '0;
        res_d   = '0;
        zero_d  = 1'b0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Grant     = grant_q;
  assign Done      = done_q;
  assign Result    = res_q;
  assign Zero      = zero_q;
  assign Carry_out = carry_q;
  assign Overflow  = ovf_q;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, handshake corner sequences and randomized
// transactions checked against an arithmetic reference model.
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int PW   = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  Req;
  logic [31:0] OpA, OpB;
  logic [15:0] OpCode;
  logic [3:0]  Grant, Done;
  logic [7:0]  Result;
  logic        Zero, Carry_out, Overflow, Busy;

  alu_share_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Req       (Req),
    .OpA       (OpA),
    .OpB       (OpB),
    .OpCode    (OpCode),
    .Grant     (Grant),
    .Done      (Done),
    .Result    (Result),
    .Zero      (Zero),
    .Carry_out (Carry_out),
    .Overflow  (Overflow),
    .Busy      (Busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int ptr = NREQ - 1;
  logic [10:0] last = '0;

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns {overflow, carry, zero, result[7:0]}.
  function automatic logic [10:0] alu_model(input int a, input int b, input int op);
    int r, s, sa, sb;
    logic c, v;
    logic [7:0] r8;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (op)
      0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
      8: begin r = a + 1; c = (r > 255); s = sa + 1;  v = (s > 127); end
      9: begin r = a - 1; c = (a < 1);   s = sa - 1;  v = (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a * 2; c = (a >= 128); end
      7: begin r = a / 2; c = (a % 2) == 1; end
      default: r = a;
    endcase
    r = ((r % 256) + 256) % 256;
    r8 = r[7:0];
    return {v, c, (r8 == 8'h00), r8};
  endfunction

  function automatic int pick(input logic [3:0] rq, input int p);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (rq[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] oh(input int i);
    logic [31:0] one;
    one = 32'd1;
    return (i < 0) ? 32'd0 : (one << i);
  endfunction

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    OpA[8*i +: 8]    = a;
    OpB[8*i +: 8]    = b;
    OpCode[4*i +: 4] = op;
  endtask

  task automatic check_outs(input string tag, input logic [10:0] e);
    chk({tag, " Result"}, 32'(Result), 32'(e[7:0]));
    chk({tag, " Zero"}, 32'(Zero), 32'(e[8]));
    chk({tag, " Carry_out"}, 32'(Carry_out), 32'(e[9]));
    chk({tag, " Overflow"}, 32'(Overflow), 32'(e[10]));
  endtask

  // One lone request through the full handshake, checking fixed latency.
  task automatic run_single(input int i, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic [10:0] e, input string tag);
    set_ops(i, a, b, op);
    Req = '0;
    Req[i] = 1'b1;
    tick();
    chk({tag, " Grant"}, 32'(Grant), oh(i));
    chk({tag, " Busy"}, 32'(Busy), 32'd1);
    tick();
    chk({tag, " early Done"}, 32'(Done), 32'd0);
    tick();
    chk({tag, " Done"}, 32'(Done), oh(i));
    check_outs(tag, e);
    last = e;
    Req[i] = 1'b0;
    tick();
    chk({tag, " Grant released"}, 32'(Grant), 32'd0);
    chk({tag, " Busy released"}, 32'(Busy), 32'd0);
    ptr = i;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, got, w, ab;
    logic [3:0] rq;
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic [3:0] ro [4];
    logic [10:0] e;

    tbl[0]  = '{0, 8'h0F, 8'h01, 4'h0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2, 8'h7F, 8'h01, 4'h0, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1, 8'h05, 8'h07, 4'h1, 8'hFE, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{3, 8'h80, 8'h01, 4'h1, 8'h7F, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{0, 8'hF0, 8'h3C, 4'h2, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1, 8'hF0, 8'h0F, 4'h3, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3, 8'hAA, 8'hAA, 4'h4, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2, 8'h55, 8'h00, 4'h5, 8'hAA, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{0, 8'h81, 8'h00, 4'h6, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1, 8'h01, 8'h00, 4'h7, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{2, 8'h7F, 8'h00, 4'h8, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{0, 8'h00, 8'h00, 4'h9, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1, 8'h42, 8'h99, 4'hF, 8'h42, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{3, 8'hFF, 8'h00, 4'h8, 8'h00, 1'b1, 1'b1, 1'b0};

    Req = '0;
    OpA = '0;
    OpB = '0;
    OpCode = '0;
    #12;
    chk("reset Grant", 32'(Grant), 32'd0);
    chk("reset Done", 32'(Done), 32'd0);
    chk("reset Busy", 32'(Busy), 32'd0);
    check_outs("reset", 11'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Vector table, single requester per transaction.
    for (int t = 0; t < 15; t++) begin
      run_single(tbl[t].r, tbl[t].a, tbl[t].b, tbl[t].op,
                 {tbl[t].v, tbl[t].c, tbl[t].z, tbl[t].res}, $sformatf("vec%0d", t));
    end

    // All four requesting: rotation order, each dropping Req right after its Done.
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'h01, 4'h0);
    Req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (n < 8 && Done == '0) begin
        tick();
        n++;
      end
      chk($sformatf("rr%0d Done seen", t), 32'(Done != '0), 32'd1);
      got = oh_idx(Done);
      w = pick(4'b1111, ptr);
      chk($sformatf("rr%0d winner", t), 32'(got), 32'(w));
      chk($sformatf("rr%0d Grant", t), 32'(Grant), oh(w));
      ptr = w;
      if (got >= 0) Req[got] = 1'b0;
      tick();
      Req = (t < 4) ? 4'b1111 : 4'b0000;
    end
    last = alu_model(0, 1, 0);
    tick();

    // Requester 1 drops Req while in LOAD: abort, then requester 2 is served.
    set_ops(2, 8'h21, 8'h12, 4'h0);
    Req = 4'b0110;
    w = pick(4'b0110, ptr);
    tick();
    chk("abort Grant", 32'(Grant), oh(w));
    Req[w] = 1'b0;
    tick();
    chk("abort Grant cleared", 32'(Grant), 32'd0);
    chk("abort no Done", 32'(Done), 32'd0);
    chk("abort Busy", 32'(Busy), 32'd0);
    check_outs("abort hold", last);
    ptr = w;
    w = pick(Req, ptr);
    tick();
    chk("post-abort Grant", 32'(Grant), oh(w));
    tick();
    tick();
    chk("post-abort Done", 32'(Done), oh(w));
    last = alu_model(8'h21, 8'h12, 0);
    check_outs("post-abort", last);
    Req = '0;
    tick();
    ptr = w;

    // Operands changed during EXEC are ignored.
    set_ops(3, 8'h10, 8'h20, 4'h0);
    Req = 4'b1000;
    tick();
    tick();
    set_ops(3, 8'h55, 8'h55, 4'h2);
    tick();
    chk("latch Done", 32'(Done), oh(3));
    last = alu_model(8'h10, 8'h20, 0);
    check_outs("latch", last);
    Req = '0;
    tick();
    ptr = 3;

    // Reset asserted during EXEC.
    set_ops(0, 8'h03, 8'h04, 4'h0);
    Req = 4'b0001;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midreset Grant", 32'(Grant), 32'd0);
    chk("midreset Done", 32'(Done), 32'd0);
    chk("midreset Busy", 32'(Busy), 32'd0);
    check_outs("midreset", 11'd0);
    tick();
    chk("midreset Done held", 32'(Done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ptr = NREQ - 1;
    Req = 4'b1111;
    tick();
    chk("post-reset Grant", 32'(Grant), oh(pick(4'b1111, ptr)));
    tick();
    tick();
    chk("post-reset Done", 32'(Done), 32'd1);
    last = alu_model(3, 4, 0);
    check_outs("post-reset", last);
    Req = '0;
    tick();
    ptr = 0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 200; t++) begin
      rq = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        ro[i] = 4'($urandom);
        set_ops(i, ra[i], rb[i], ro[i]);
      end
      w = pick(rq, ptr);
      ab = ($urandom_range(0, 4) == 0) ? 1 : 0;
      Req = rq;
      tick();
      chk($sformatf("rnd%0d Grant", t), 32'(Grant), oh(w));
      if (ab != 0) begin
        Req[w] = 1'b0;
        tick();
        chk($sformatf("rnd%0d abort Grant", t), 32'(Grant), 32'd0);
        chk($sformatf("rnd%0d abort Done", t), 32'(Done), 32'd0);
        check_outs($sformatf("rnd%0d abort", t), last);
        Req = '0;
        tick();
      end else begin
        tick();
        set_ops(w, 8'($urandom), 8'($urandom), 4'($urandom));
        tick();
        chk($sformatf("rnd%0d Done", t), 32'(Done), oh(w));
        e = alu_model(int'(ra[w]), int'(rb[w]), int'(ro[w]));
        check_outs($sformatf("rnd%0d", t), e);
        last = e;
        Req = '0;
        tick();
        chk($sformatf("rnd%0d Busy", t), 32'(Busy), 32'd0);
      end
      ptr = w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
